// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC and chooses advance / hold / redirect / halt each cycle.
// Latency: every decision uses inputs sampled at a posedge and appears on the registered outputs after that edge.
// Backpressure: hazard holds the PC and drops fetch_valid; flush stays high for FLUSH_CYCLES cycles after a redirect.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [5:0]  HALT_OPC     = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] instruction,
  input  logic        resume,
  output logic [31:0] pc_out,
  output logic        fetch_valid,
  output logic        flush,
  output logic        halted,
  output logic        err_misalign,
  output logic [15:0] stall_cnt
);

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    STALL,
    FLUSH,
    HALT
  } state_t;

  state_t      state;
  logic [2:0]  flush_cnt;
  logic [31:0] pc_next_seq;
  logic [15:0] stall_cnt_inc;
  logic        halt_word;

  // Only the opcode field matters for halt detection; the rest of the word is decode's business.
  logic        unused_instr;
  assign unused_instr = ^instruction[25:0];

  // Sequential next PC (wraps naturally mod 2^32) and saturating stall increment.
  assign pc_next_seq   = pc_out + 32'd4;
  assign stall_cnt_inc = (stall_cnt == 16'hFFFF) ? stall_cnt : stall_cnt + 16'd1;
  assign halt_word     = (instruction[31:26] == HALT_OPC);

  // Fetch FSM: redirect beats hazard beats halt-detect beats sequential advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= BOOT;
      pc_out       <= RESET_PC;
      fetch_valid  <= 1'b0;
      flush        <= 1'b0;
      halted       <= 1'b0;
      err_misalign <= 1'b0;
      stall_cnt    <= 16'd0;
      flush_cnt    <= 3'd0;
    end else begin
      case (state)
        BOOT: begin
          // One settling cycle with the reset PC held and nothing valid.
          state       <= RUN;
          fetch_valid <= 1'b0;
          flush       <= 1'b0;
        end
        default: begin
          if (br_taken) begin
            // Redirect: honoured in every post-boot state, including HALT (older in-flight branch).
            pc_out      <= {br_target[31:2], 2'b00};
            state       <= FLUSH;
            flush_cnt   <= 3'(FLUSH_CYCLES);
            flush       <= 1'b1;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
            if (br_target[1:0] != 2'b00) begin
              err_misalign <= 1'b1;
            end
          end else if (state == HALT) begin
            // Hazard is meaningless while halted; only resume leaves.
            if (resume) begin
              pc_out      <= pc_next_seq;
              state       <= RUN;
              fetch_valid <= 1'b1;
              halted      <= 1'b0;
            end
          end else if (state == FLUSH) begin
            // The squash window runs down even while decode is stalling.
            flush_cnt <= flush_cnt - 3'd1;
            if (hazard) begin
              stall_cnt <= stall_cnt_inc;
            end else begin
              pc_out <= pc_next_seq;
            end
            if (flush_cnt == 3'd1) begin
              flush       <= 1'b0;
              fetch_valid <= !hazard;
              state       <= hazard ? STALL : RUN;
            end else begin
              flush       <= 1'b1;
              fetch_valid <= 1'b0;
            end
          end else if (hazard) begin
            state       <= STALL;
            fetch_valid <= 1'b0;
            flush       <= 1'b0;
            stall_cnt   <= stall_cnt_inc;
          end else if (state == RUN && fetch_valid && halt_word) begin
            // Park on the halt word itself so resume continues just past it.
            state       <= HALT;
            fetch_valid <= 1'b0;
            halted      <= 1'b1;
          end else begin
            pc_out      <= pc_next_seq;
            state       <= RUN;
            fetch_valid <= 1'b1;
            flush       <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
